// File: rtl/sevseg_scan_ctrl.sv
// Eight-digit multiplexed seven-segment scanner with a small Wishbone register file.
// Digits are driven one at a time (DRIVE) separated by all-off dead time (BLANK);
// the displayed DATA/MASK come from shadow copies refreshed only at frame start.
`timescale 1ns/1ps
module sevseg_scan_ctrl #(
  parameter int unsigned PRESCALE = 50000,
  parameter int unsigned BLANK    = 500
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [1:0]  i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  output logic        o_wb_ack,
  output logic [31:0] o_wb_rdt,
  output logic [7:0]  o_an,
  output logic [6:0]  o_seg,
  output logic        o_frame
);

  typedef enum logic [1:0] {StIdle, StBlank, StDrive} state_e;

  // Counter only has to reach the larger of the two phase lengths minus one.
  localparam int unsigned CntMax = (PRESCALE > BLANK) ? PRESCALE : BLANK;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK - 1);
  localparam logic [CntW-1:0] DriveLast = CntW'(PRESCALE - 1);

  logic [31:0]     data_q, data_d, sh_data_q;
  logic [7:0]      mask_q, mask_d, sh_mask_q;
  logic            run_q, run_d, pend_q, pend_d;
  logic            ack_q;
  logic [31:0]     rdt_q, rdt_d;
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d, first_idx, nxt_idx;
  logic            has_next, load;
  logic [7:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            frame_q, frame_d;
  logic            req, wr, rd;

  // Accept a request only when no ack is outstanding, so a held strobe acks every other cycle.
  assign req = i_wb_cyc & i_wb_stb & ~ack_q;
  assign wr  = req & i_wb_we;
  assign rd  = req & ~i_wb_we;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    unique case (v)
      4'h0: seg_decode = 7'b0000001;
      4'h1: seg_decode = 7'b1001111;
      4'h2: seg_decode = 7'b0010010;
      4'h3: seg_decode = 7'b0000110;
      4'h4: seg_decode = 7'b1001100;
      4'h5: seg_decode = 7'b0100100;
      4'h6: seg_decode = 7'b0100000;
      4'h7: seg_decode = 7'b0001111;
      4'h8: seg_decode = 7'b0000000;
      4'h9: seg_decode = 7'b0000100;
      4'hA: seg_decode = 7'b0001000;
      4'hB: seg_decode = 7'b1100000;
      4'hC: seg_decode = 7'b0110001;
      4'hD: seg_decode = 7'b1000010;
      4'hE: seg_decode = 7'b0110000;
      4'hF: seg_decode = 7'b0111000;
    endcase
  endfunction

  // Register writes land at the edge that raises ack; read data is presented only on ack.
  always_comb begin
    data_d = data_q;
    mask_d = mask_q;
    run_d  = run_q;
    pend_d = pend_q;
    rdt_d  = '0;
    if (load) pend_d = 1'b0;
    if (wr) begin
      case (i_wb_adr)
        2'd0: begin data_d = i_wb_dat;      pend_d = 1'b1; end
        2'd1: begin mask_d = i_wb_dat[7:0]; pend_d = 1'b1; end
        2'd2: run_d = i_wb_dat[0];
        default: ;
      endcase
    end
    if (rd) begin
      case (i_wb_adr)
        2'd0:    rdt_d = data_q;
        2'd1:    rdt_d = {24'd0, mask_q};
        2'd2:    rdt_d = {30'd0, pend_q, run_q};
        default: rdt_d = '0;
      endcase
    end
  end

  // Lowest enabled digit of the live mask (the index used after a shadow load).
  always_comb begin
    first_idx = 3'd0;
    for (int j = 7; j >= 0; j--) begin
      if (mask_q[j]) first_idx = 3'(j);
    end
  end

  // Next enabled digit above the current one in the shadow mask; none means wrap.
  always_comb begin
    has_next = 1'b0;
    nxt_idx  = idx_q;
    for (int j = 7; j >= 0; j--) begin
      if (sh_mask_q[j] && (3'(j) > idx_q)) begin
        has_next = 1'b1;
        nxt_idx  = 3'(j);
      end
    end
  end

  // Scan FSM next state, plus registered-output next values derived from it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    load    = 1'b0;
    frame_d = 1'b0;
    an_d    = 8'hFF;
    seg_d   = 7'h7F;
    unique case (state_q)
      StIdle: begin
        if (run_q && (mask_q != 8'd0)) begin
          load    = 1'b1;
          frame_d = 1'b1;
          idx_d   = first_idx;
          cnt_d   = '0;
          state_d = StBlank;
        end
      end
      StBlank: begin
        if (cnt_q == BlankLast) begin
          cnt_d   = '0;
          state_d = StDrive;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDrive: begin
        if (cnt_q == DriveLast) begin
          cnt_d = '0;
          if (has_next) begin
            idx_d   = nxt_idx;
            state_d = StBlank;
          end else begin
            load    = 1'b1;
            frame_d = 1'b1;
            idx_d   = first_idx;
            state_d = (mask_q == 8'd0) ? StIdle : StBlank;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    // Clearing RUN wins over everything, taking effect at the same edge as the write.
    if (!run_d) begin
      state_d = StIdle;
      cnt_d   = '0;
      load    = 1'b0;
      frame_d = 1'b0;
    end
    // Shadows and index are stable whenever the next state is DRIVE.
    if (state_d == StDrive) begin
      an_d[idx_q] = 1'b0;
      seg_d       = seg_decode(sh_data_q[{idx_q, 2'b00} +: 4]);
    end
  end

  // All state and outputs registered; async active-low reset forces everything off.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_q    <= '0;
      mask_q    <= '0;
      run_q     <= 1'b0;
      pend_q    <= 1'b0;
      ack_q     <= 1'b0;
      rdt_q     <= '0;
      state_q   <= StIdle;
      cnt_q     <= '0;
      idx_q     <= '0;
      sh_data_q <= '0;
      sh_mask_q <= '0;
      an_q      <= 8'hFF;
      seg_q     <= 7'h7F;
      frame_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      mask_q  <= mask_d;
      run_q   <= run_d;
      pend_q  <= pend_d;
      ack_q   <= req;
      rdt_q   <= rdt_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      frame_q <= frame_d;
      if (load) begin
        sh_data_q <= data_q;
        sh_mask_q <= mask_q;
      end
    end
  end

  assign o_wb_ack = ack_q;
  assign o_wb_rdt = rdt_q;
  assign o_an     = an_q;
  assign o_seg    = seg_q;
  assign o_frame  = frame_q;

endmodule

// File: tb/tb_sevseg_scan_ctrl.sv
// Randomised bench for sevseg_scan_ctrl against a slot-arithmetic display model.
`timescale 1ns/1ps
module tb_sevseg_scan_ctrl;

  localparam int P = 4;
  localparam int B = 2;

  localparam logic [6:0] SEG_TBL [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100,
    7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  logic        clk = 1'b0;
  logic        rstn;
  logic [1:0]  i_wb_adr;
  logic [31:0] i_wb_dat;
  logic        i_wb_we, i_wb_cyc, i_wb_stb;
  logic        o_wb_ack;
  logic [31:0] o_wb_rdt;
  logic [7:0]  o_an;
  logic [6:0]  o_seg;
  logic        o_frame;

  int n_vec = 0;
  int n_err = 0;
  int cyc_cnt = 0;

  sevseg_scan_ctrl #(.PRESCALE(P), .BLANK(B)) dut (
    .clk(clk), .rstn(rstn), .i_wb_adr(i_wb_adr), .i_wb_dat(i_wb_dat), .i_wb_we(i_wb_we),
    .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .o_wb_ack(o_wb_ack), .o_wb_rdt(o_wb_rdt),
    .o_an(o_an), .o_seg(o_seg), .o_frame(o_frame)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Display model: t cycles after a frame pulse, which digit (if any) is lit.
  function automatic void model(input int t, input logic [31:0] d, input logic [7:0] m,
                                output logic [7:0] an, output logic [6:0] seg,
                                output logic fr);
    int lst[8];
    int n, per, tt, k, r;
    n = 0;
    for (int j = 0; j < 8; j++) if (m[j]) begin lst[n] = j; n++; end
    per = n * (B + P);
    tt  = t % per;
    k   = tt / (B + P);
    r   = tt % (B + P);
    fr  = (tt == 0);
    an  = 8'hFF;
    seg = 7'h7F;
    if (r >= B) begin
      an[lst[k]] = 1'b0;
      seg        = SEG_TBL[d[lst[k]*4 +: 4]];
    end
  endfunction

  function automatic int n_en(input logic [7:0] m);
    n_en = 0;
    for (int j = 0; j < 8; j++) if (m[j]) n_en++;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [1:0] a, input logic [31:0] d);
    logic got;
    got = 1'b0;
    i_wb_adr = a; i_wb_dat = d; i_wb_we = 1'b1; i_wb_cyc = 1'b1; i_wb_stb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (o_wb_ack) begin got = 1'b1; break; end
    end
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
    n_vec++;
    if (!got) begin n_err++; $display("FAIL wb_write_ack adr=%0d: ack=0 required 1", a); end
  endtask

  task automatic wb_read(input logic [1:0] a, output logic [31:0] d);
    logic got;
    got = 1'b0;
    d = 32'hDEADBEEF;
    i_wb_adr = a; i_wb_we = 1'b0; i_wb_cyc = 1'b1; i_wb_stb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (o_wb_ack) begin got = 1'b1; d = o_wb_rdt; break; end
    end
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
    n_vec++;
    if (!got) begin n_err++; $display("FAIL wb_read_ack adr=%0d: ack=0 required 1", a); end
  endtask

  task automatic wait_frame(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 120; i++) begin
      if (o_frame) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    n_vec++;
    if (o_an !== 8'hFF || o_seg !== 7'h7F || o_frame !== 1'b0 || o_wb_ack !== 1'b0 ||
        o_wb_rdt !== 32'd0) begin
      n_err++;
      $display("FAIL reset_outputs: an=%h seg=%b frame=%b ack=%b rdt=%h required FF 1111111 0 0 0",
               o_an, o_seg, o_frame, o_wb_ack, o_wb_rdt);
    end
    for (int a = 0; a < 4; a++) begin
      wb_read(2'(a), rd);
      n_vec++;
      if (rd !== 32'd0) begin
        n_err++; $display("FAIL reset_reg adr=%0d: read %h required 0", a, rd);
      end
    end
  endtask

  task automatic test_full_frame();
    logic [31:0] d;
    logic [7:0]  ea;
    logic [6:0]  es;
    logic        ef;
    bit          ok;
    d = 32'h76543210;
    wb_write(2'd0, d);
    wb_write(2'd1, 32'hFF);
    wb_write(2'd2, 32'h1);
    wait_frame(ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL full_frame_start: frame=0 required 1"); end
    for (int t = 0; t < 2 * 48; t++) begin
      model(t, d, 8'hFF, ea, es, ef);
      n_vec++;
      if (o_an !== ea || o_seg !== es || o_frame !== ef) begin
        n_err++;
        $display("FAIL full_frame t=%0d: an=%h seg=%b fr=%b required an=%h seg=%b fr=%b",
                 t, o_an, o_seg, o_frame, ea, es, ef);
      end
      tick();
    end
    n_vec++;
    if (o_frame !== 1'b1) begin n_err++; $display("FAIL full_frame_period: frame=%b required 1", o_frame); end
  endtask

  task automatic test_random_frames();
    logic [31:0] d, rd;
    logic [7:0]  m, ea;
    logic [6:0]  es;
    logic        ef;
    bit          ok;
    int          per;
    for (int it = 0; it < 6; it++) begin
      d = $urandom;
      m = (it == 0) ? 8'h24 : 8'($urandom);
      if (m == 8'd0) m = 8'h80;
      per = n_en(m) * (B + P);
      wb_write(2'd2, 32'h0);
      wb_write(2'd0, d);
      wb_write(2'd1, {24'd0, m});
      wb_write(2'd2, 32'h1);
      wait_frame(ok);
      n_vec++;
      if (!ok) begin n_err++; $display("FAIL rand_frame_start it=%0d: frame=0 required 1", it); end
      for (int t = 0; t < 2 * per; t++) begin
        model(t, d, m, ea, es, ef);
        n_vec++;
        if (o_an !== ea || o_seg !== es || o_frame !== ef) begin
          n_err++;
          $display("FAIL rand_frame it=%0d m=%h t=%0d: an=%h seg=%b fr=%b required an=%h seg=%b fr=%b",
                   it, m, t, o_an, o_seg, o_frame, ea, es, ef);
        end
        tick();
      end
      n_vec++;
      if (o_frame !== 1'b1) begin
        n_err++; $display("FAIL rand_frame_period it=%0d: frame=%b required 1", it, o_frame);
      end
      wb_read(2'd2, rd);
      n_vec++;
      if (rd !== 32'h1) begin n_err++; $display("FAIL rand_ctrl it=%0d: read %h required 1", it, rd); end
    end
  endtask

  task automatic test_pending();
    logic [31:0] d1, d2, rd;
    logic [7:0]  ea;
    logic [6:0]  es;
    logic        ef;
    bit          ok;
    int          f, t;
    d1 = $urandom;
    d2 = 32'h88888888;
    wb_write(2'd2, 32'h0);
    wb_write(2'd0, d1);
    wb_write(2'd1, 32'hFF);
    wb_write(2'd2, 32'h1);
    wait_frame(ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL pend_frame_start: frame=0 required 1"); end
    f = cyc_cnt;
    for (int i = 0; i < 10; i++) begin
      model(cyc_cnt - f, d1, 8'hFF, ea, es, ef);
      n_vec++;
      if (o_an !== ea || o_seg !== es || o_frame !== ef) begin
        n_err++; $display("FAIL pend_old_pre t=%0d: an=%h seg=%b required an=%h seg=%b",
                          cyc_cnt - f, o_an, o_seg, ea, es);
      end
      tick();
    end
    wb_write(2'd0, d2);
    wb_read(2'd2, rd);
    n_vec++;
    if (rd !== 32'h3) begin n_err++; $display("FAIL pend_set: ctrl read %h required 3", rd); end
    t = cyc_cnt - f;
    while (t < 48) begin
      model(t, d1, 8'hFF, ea, es, ef);
      n_vec++;
      if (o_an !== ea || o_seg !== es || o_frame !== ef) begin
        n_err++; $display("FAIL pend_old_post t=%0d: an=%h seg=%b fr=%b required an=%h seg=%b fr=%b",
                          t, o_an, o_seg, o_frame, ea, es, ef);
      end
      tick();
      t = cyc_cnt - f;
    end
    for (int u = 48; u < 96; u++) begin
      model(u, d2, 8'hFF, ea, es, ef);
      n_vec++;
      if (o_an !== ea || o_seg !== es || o_frame !== ef) begin
        n_err++; $display("FAIL pend_new t=%0d: an=%h seg=%b fr=%b required an=%h seg=%b fr=%b",
                          u, o_an, o_seg, o_frame, ea, es, ef);
      end
      tick();
    end
    wb_read(2'd2, rd);
    n_vec++;
    if (rd !== 32'h1) begin n_err++; $display("FAIL pend_clear: ctrl read %h required 1", rd); end
  endtask

  task automatic test_stop();
    logic [31:0] rd;
    bit          ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (o_an !== 8'hFF) begin ok = 1'b1; break; end
      tick();
    end
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL stop_find_drive: no digit lit, required one"); end
    wb_write(2'd2, 32'h0);
    n_vec++;
    if (o_an !== 8'hFF || o_seg !== 7'h7F) begin
      n_err++; $display("FAIL stop_off: an=%h seg=%b required FF 1111111", o_an, o_seg);
    end
    wb_write(2'd1, 32'h0);
    wb_write(2'd2, 32'h1);
    for (int i = 0; i < 30; i++) begin
      n_vec++;
      if (o_an !== 8'hFF || o_frame !== 1'b0) begin
        n_err++; $display("FAIL stop_idle i=%0d: an=%h frame=%b required FF 0", i, o_an, o_frame);
      end
      tick();
    end
    wb_read(2'd2, rd);
    n_vec++;
    if (rd !== 32'h3) begin n_err++; $display("FAIL stop_ctrl: read %h required 3", rd); end
    wb_write(2'd2, 32'h0);
  endtask

  task automatic test_held_read();
    logic [7:0]  m;
    logic [31:0] rd, er;
    logic        ea;
    m = 8'($urandom);
    wb_write(2'd1, {$urandom, m});
    tick();
    i_wb_adr = 2'd1; i_wb_we = 1'b0; i_wb_cyc = 1'b1; i_wb_stb = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      ea = (i % 2) == 1;
      er = ea ? {24'd0, m} : 32'd0;
      n_vec++;
      if (o_wb_ack !== ea || o_wb_rdt !== er) begin
        n_err++; $display("FAIL held_read i=%0d: ack=%b rdt=%h required ack=%b rdt=%h",
                          i, o_wb_ack, o_wb_rdt, ea, er);
      end
    end
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
    tick();
    wb_write(2'd3, $urandom);
    wb_read(2'd3, rd);
    n_vec++;
    if (rd !== 32'd0) begin n_err++; $display("FAIL adr3_read: read %h required 0", rd); end
    wb_read(2'd1, rd);
    n_vec++;
    if (rd !== {24'd0, m}) begin n_err++; $display("FAIL mask_keep: read %h required %h", rd, m); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    bit          ok;
    wb_write(2'd0, $urandom);
    wb_write(2'd1, 32'hFF);
    wb_write(2'd2, 32'h1);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (o_an !== 8'hFF) begin ok = 1'b1; break; end
      tick();
    end
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL rstmid_find_drive: no digit lit, required one"); end
    i_wb_adr = 2'd0; i_wb_dat = $urandom; i_wb_we = 1'b1; i_wb_cyc = 1'b1; i_wb_stb = 1'b1;
    #2 rstn = 1'b0;
    #1;
    n_vec++;
    if (o_an !== 8'hFF || o_seg !== 7'h7F || o_frame !== 1'b0 || o_wb_ack !== 1'b0) begin
      n_err++; $display("FAIL rstmid_now: an=%h seg=%b frame=%b ack=%b required FF 1111111 0 0",
                        o_an, o_seg, o_frame, o_wb_ack);
    end
    tick();
    n_vec++;
    if (o_wb_ack !== 1'b0 || o_an !== 8'hFF) begin
      n_err++; $display("FAIL rstmid_hold: ack=%b an=%h required 0 FF", o_wb_ack, o_an);
    end
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
    rstn = 1'b1;
    tick();
    for (int a = 0; a < 3; a++) begin
      wb_read(2'(a), rd);
      n_vec++;
      if (rd !== 32'd0) begin n_err++; $display("FAIL rstmid_reg adr=%0d: read %h required 0", a, rd); end
    end
    for (int i = 0; i < 20; i++) begin
      n_vec++;
      if (o_an !== 8'hFF || o_frame !== 1'b0) begin
        n_err++; $display("FAIL rstmid_idle i=%0d: an=%h frame=%b required FF 0", i, o_an, o_frame);
      end
      tick();
    end
  endtask

  initial begin
    rstn = 1'b0;
    i_wb_adr = '0; i_wb_dat = '0; i_wb_we = 1'b0; i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    test_reset();
    test_full_frame();
    test_random_frames();
    test_pending();
    test_stop();
    test_held_read();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

endmodule
